// File: rtl/w_writeback_grf.sv
// ============================================================================
// Module   : w_writeback_grf
// Purpose  : Writeback stage: decodes W_Instr, writes the 32x32 GRF, serves two
//            bypassed D-stage read ports and counts retired instructions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module w_writeback_grf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      W_PC,
    input  logic [31:0]      W_Instr,
    input  logic [31:0]      W_ALUresult,
    input  logic [31:0]      W_RD,
    input  logic [31:0]      W_HILOout,
    input  logic [4:0]       D_rs_addr,
    input  logic [4:0]       D_rt_addr,
    output logic [31:0]      D_rs_data,
    output logic [31:0]      D_rt_data,
    output logic             W_we,
    output logic [4:0]       W_waddr,
    output logic [31:0]      W_wdata,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [1:0] c_SRC_ALU  = 2'd0;
    localparam logic [1:0] c_SRC_MEM  = 2'd1;
    localparam logic [1:0] c_SRC_HILO = 2'd2;
    localparam logic [1:0] c_SRC_PC8  = 2'd3;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_dec_we;
    logic [4:0]  w_dec_dst;
    logic [1:0]  w_src;
    logic [31:0] w_src_data;
    logic [31:0] r_regs [0:31];
    logic [CNT_W-1:0] r_cnt;

    assign w_op    = W_Instr[31:26];
    assign w_funct = W_Instr[5:0];

    always_comb begin
        w_dec_we  = 1'b0;
        w_dec_dst = W_Instr[20:16];
        w_src     = c_SRC_ALU;
        if (w_op == 6'h00) begin
            w_dec_dst = W_Instr[15:11];
            case (w_funct)
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03: w_dec_we = 1'b1;
                6'h10, 6'h12: begin
                    w_dec_we = 1'b1;
                    w_src    = c_SRC_HILO;
                end
                6'h09: begin
                    w_dec_we = 1'b1;
                    w_src    = c_SRC_PC8;
                end
                default: w_dec_we = 1'b0;
            endcase
        end else begin
            case (w_op)
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
                    w_dec_we = 1'b1;
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    w_dec_we = 1'b1;
                    w_src    = c_SRC_MEM;
                end
                6'h03: begin
                    w_dec_we  = 1'b1;
                    w_dec_dst = 5'd31;
                    w_src     = c_SRC_PC8;
                end
                default: w_dec_we = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (w_src)
            c_SRC_MEM:  w_src_data = W_RD;
            c_SRC_HILO: w_src_data = W_HILOout;
            c_SRC_PC8:  w_src_data = W_PC + 32'd8;
            default:    w_src_data = W_ALUresult;
        endcase
    end

    // Writes to $0 are squashed here so every consumer sees a clean strobe.
    assign W_we    = w_dec_we && (w_dec_dst != 5'd0);
    assign W_waddr = W_we ? w_dec_dst  : 5'd0;
    assign W_wdata = W_we ? w_src_data : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (W_we) begin
            r_regs[W_waddr] <= W_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (W_Instr != 32'd0) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign retire_cnt = r_cnt;

    // Bypass bypasses the reset too: the write-side outputs are purely combinational.
    always_comb begin
        if (D_rs_addr == 5'd0) begin
            D_rs_data = 32'd0;
        end else if (W_we && (D_rs_addr == W_waddr)) begin
            D_rs_data = W_wdata;
        end else begin
            D_rs_data = r_regs[D_rs_addr];
        end
    end

    always_comb begin
        if (D_rt_addr == 5'd0) begin
            D_rt_data = 32'd0;
        end else if (W_we && (D_rt_addr == W_waddr)) begin
            D_rt_data = W_wdata;
        end else begin
            D_rt_data = r_regs[D_rt_addr];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_w_writeback_grf.sv
// ============================================================================
// Module   : tb_w_writeback_grf
// Purpose  : Directed, table-driven self-checking bench for w_writeback_grf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_w_writeback_grf;

    logic        clk;
    logic        clk_run;
    logic        reset;
    logic [31:0] W_PC, W_Instr, W_ALUresult, W_RD, W_HILOout;
    logic [4:0]  D_rs_addr, D_rt_addr;
    logic [31:0] D_rs_data, D_rt_data;
    logic        W_we;
    logic [4:0]  W_waddr;
    logic [31:0] W_wdata;
    logic [31:0] retire_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_cnt;

    w_writeback_grf #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .W_PC       (W_PC),
        .W_Instr    (W_Instr),
        .W_ALUresult(W_ALUresult),
        .W_RD       (W_RD),
        .W_HILOout  (W_HILOout),
        .D_rs_addr  (D_rs_addr),
        .D_rt_addr  (D_rt_addr),
        .D_rs_data  (D_rs_data),
        .D_rt_data  (D_rt_data),
        .W_we       (W_we),
        .W_waddr    (W_waddr),
        .W_wdata    (W_wdata),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [31:0] hilo;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_bubble(input logic [4:0] rs, input logic [4:0] rt);
        W_Instr   = 32'd0;
        W_PC      = 32'd0;
        W_ALUresult = 32'd0;
        W_RD      = 32'd0;
        W_HILOout = 32'd0;
        D_rs_addr = rs;
        D_rt_addr = rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            instr         pc            alu           rdat          hilo          rs     rt     we    waddr  wdata         rs_d          rt_d
        tv[0]  = '{32'h34081234, 32'h00003000, 32'h00001234, 32'h00000000, 32'h00000000, 5'd8,  5'd0,  1'b1, 5'd8,  32'h00001234, 32'h00001234, 32'h00000000};
        tv[1]  = '{32'h8C090000, 32'h00003004, 32'h11111111, 32'hDEADBEEF, 32'h00000000, 5'd9,  5'd8,  1'b1, 5'd9,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00001234};
        tv[2]  = '{32'h00005012, 32'h00003008, 32'h00000099, 32'h00000055, 32'h00000007, 5'd10, 5'd9,  1'b1, 5'd10, 32'h00000007, 32'h00000007, 32'hDEADBEEF};
        tv[3]  = '{32'h0C000000, 32'h00003000, 32'h00000123, 32'h00000456, 32'h00000789, 5'd31, 5'd10, 1'b1, 5'd31, 32'h00003008, 32'h00003008, 32'h00000007};
        tv[4]  = '{32'h24000005, 32'h00003010, 32'h00000005, 32'h00000000, 32'h00000000, 5'd8,  5'd0,  1'b0, 5'd0,  32'h00000000, 32'h00001234, 32'h00000000};
        tv[5]  = '{32'hAC090000, 32'h00003014, 32'h00000055, 32'h00000066, 32'h00000077, 5'd9,  5'd8,  1'b0, 5'd0,  32'h00000000, 32'hDEADBEEF, 32'h00001234};
        tv[6]  = '{32'h11090004, 32'h00003018, 32'h00000001, 32'h00000002, 32'h00000003, 5'd31, 5'd10, 1'b0, 5'd0,  32'h00000000, 32'h00003008, 32'h00000007};
        tv[7]  = '{32'h03E02809, 32'hFFFFFFFC, 32'h00000011, 32'h00000022, 32'h00000033, 5'd5,  5'd0,  1'b1, 5'd5,  32'h00000004, 32'h00000004, 32'h00000000};
        tv[8]  = '{32'h00003021, 32'h00003020, 32'hCAFEF00D, 32'h00000000, 32'h00000001, 5'd6,  5'd5,  1'b1, 5'd6,  32'hCAFEF00D, 32'hCAFEF00D, 32'h00000004};
        tv[9]  = '{32'h00003818, 32'h00003024, 32'h00000001, 32'h00000002, 32'h00000003, 5'd7,  5'd6,  1'b0, 5'd0,  32'h00000000, 32'h00000000, 32'hCAFEF00D};
        tv[10] = '{32'h800B0000, 32'h00003028, 32'h00000001, 32'h000000FF, 32'h00000003, 5'd11, 5'd11, 1'b1, 5'd11, 32'h000000FF, 32'h000000FF, 32'h000000FF};
        tv[11] = '{32'hFC0C0000, 32'h0000302C, 32'h00000042, 32'h00000043, 32'h00000044, 5'd12, 5'd11, 1'b0, 5'd0,  32'h00000000, 32'h00000000, 32'h000000FF};
        tv[12] = '{32'h3C0D0001, 32'h00003030, 32'h00010000, 32'h00000000, 32'h00000000, 5'd13, 5'd4,  1'b1, 5'd13, 32'h00010000, 32'h00010000, 32'h00000000};

        clk_run = 1'b0;
        reset   = 1'b1;
        drive_bubble(5'd0, 5'd0);
        exp_cnt = 32'd0;

        // Reset with the clock stopped, then sweep every register.
        #5 reset = 1'b0;
        #10 chk("reset_cnt", retire_cnt, 32'd0);
        reset = 1'b1;
        #5;
        for (int a = 0; a < 32; a++) begin
            D_rs_addr = 5'(a);
            D_rt_addr = 5'(31 - a);
            #1;
            chk($sformatf("reset_rs%0d", a), D_rs_data, 32'd0);
            chk($sformatf("reset_rt%0d", 31 - a), D_rt_data, 32'd0);
        end

        clk_run = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            W_Instr     = tv[i].instr;
            W_PC        = tv[i].pc;
            W_ALUresult = tv[i].alu;
            W_RD        = tv[i].rdat;
            W_HILOout   = tv[i].hilo;
            D_rs_addr   = tv[i].rs;
            D_rt_addr   = tv[i].rt;
            #2;
            chk($sformatf("v%0d_we", i),    {31'd0, W_we}, {31'd0, tv[i].we});
            chk($sformatf("v%0d_waddr", i), {27'd0, W_waddr}, {27'd0, tv[i].waddr});
            chk($sformatf("v%0d_wdata", i), W_wdata, tv[i].wdata);
            chk($sformatf("v%0d_rs", i),    D_rs_data, tv[i].rs_d);
            chk($sformatf("v%0d_rt", i),    D_rt_data, tv[i].rt_d);
            chk($sformatf("v%0d_cnt", i),   retire_cnt, exp_cnt);
            @(posedge clk); #1;
            exp_cnt = exp_cnt + 32'd1;
        end

        // Array contents after the edges, then three bubbles leave the count alone.
        drive_bubble(5'd8, 5'd9);
        #1;
        chk("arr_r8", D_rs_data, 32'h00001234);
        chk("arr_r9", D_rt_data, 32'hDEADBEEF);
        D_rs_addr = 5'd31; D_rt_addr = 5'd13;
        #1;
        chk("arr_r31", D_rs_data, 32'h00003008);
        chk("arr_r13", D_rt_data, 32'h00010000);
        chk("cnt_after_vec", retire_cnt, exp_cnt);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_bubbles", retire_cnt, exp_cnt);
        D_rs_addr = 5'd12; D_rt_addr = 5'd7;
        #1;
        chk("arr_r12_nowrite", D_rs_data, 32'd0);
        chk("arr_r7_nowrite", D_rt_data, 32'd0);

        // Asynchronous reset between edges.
        W_Instr = 32'h34055555; W_ALUresult = 32'hAAAA5555; D_rs_addr = 5'd5;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 32'd1;
        drive_bubble(5'd5, 5'd6);
        #1;
        chk("pre_rst_r5", D_rs_data, 32'hAAAA5555);
        chk("pre_rst_cnt", retire_cnt, exp_cnt);
        #1 reset = 1'b0;
        #1;
        chk("rst_r5", D_rs_data, 32'd0);
        chk("rst_r6", D_rt_data, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        W_Instr = 32'h34055555; W_ALUresult = 32'hAAAA5555;
        #1;
        chk("rst_bypass_we", {31'd0, W_we}, 32'd1);
        chk("rst_bypass_r5", D_rs_data, 32'hAAAA5555);
        @(posedge clk); #1;
        drive_bubble(5'd5, 5'd0);
        #1;
        chk("rst_write_lost", D_rs_data, 32'd0);
        chk("rst_cnt_held", retire_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("release_cnt", retire_cnt, 32'd0);
        W_Instr = 32'h34055555; W_ALUresult = 32'hAAAA5555;
        @(posedge clk); #1;
        drive_bubble(5'd5, 5'd0);
        #1;
        chk("post_rel_r5", D_rs_data, 32'hAAAA5555);
        chk("post_rel_cnt", retire_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
